// File: rtl/trace_round_sequencer.sv
// Round sequencer for the spell-trace game: fetches a target pattern per
// round, shows it, judges both players' traces, arbitrates ties, keeps score
// and ends the game after NUM_ROUNDS rounds.
module trace_round_sequencer #(
  parameter int NUM_ROUNDS    = 5,
  parameter int ROUND_TIMEOUT = 250000000,
  parameter int RESULT_CYCLES = 50000000,
  parameter int TMR_W         = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        two_player_mode,
  input  logic [15:0] p1_traced,
  input  logic        p1_valid,
  input  logic [15:0] p2_traced,
  input  logic        p2_valid,
  output logic        pattern_req,
  input  logic        pattern_ack,
  input  logic [15:0] pattern_in,
  output logic [15:0] trace_to_display,
  output logic        trace_screen_on,
  output logic [2:0]  round,
  output logic [2:0]  p1_score,
  output logic [2:0]  p2_score,
  output logic [1:0]  round_winner,
  output logic        result_valid,
  output logic        game_over
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_RESULT, S_DONE} state_t;

  // A zero pattern from the generator would be trivially matched, so a fixed
  // default glyph is shown instead.
  localparam logic [15:0]      DEFAULT_PATTERN = 16'h0231;
  localparam logic [TMR_W-1:0] PLAY_LAST       = TMR_W'(ROUND_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] RESULT_LAST     = TMR_W'(RESULT_CYCLES - 1);
  localparam logic [2:0]       LAST_ROUND      = 3'(NUM_ROUNDS - 1);

  state_t            state_q, state_d;
  logic [2:0]        round_q, round_d;
  logic [2:0]        p1_score_q, p1_score_d;
  logic [2:0]        p2_score_q, p2_score_d;
  logic [1:0]        winner_q, winner_d;
  logic              result_valid_q, result_valid_d;
  logic [15:0]       trace_q, trace_d;
  logic              prio_q, prio_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic              hit1, hit2;
  logic              p1_takes;
  logic [2:0]        p1_inc, p2_inc;

  // A trace hits when it covers every segment of the target; extra segments are allowed.
  assign hit1 = p1_valid && ((p1_traced & trace_q) == trace_q);
  assign hit2 = two_player_mode && p2_valid && ((p2_traced & trace_q) == trace_q);
  assign p1_takes = hit1 && !(hit2 && prio_q);
  assign p1_inc = (p1_score_q == 3'd7) ? 3'd7 : p1_score_q + 3'd1;
  assign p2_inc = (p2_score_q == 3'd7) ? 3'd7 : p2_score_q + 3'd1;

  // Next-state and next-value logic for the whole game sequence; abort overrides everything.
  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    winner_d       = winner_q;
    result_valid_d = 1'b0;
    trace_d        = trace_q;
    prio_d         = prio_q;
    timer_d        = timer_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_IDLE || start) begin
          round_d    = 3'd0;
          p1_score_d = 3'd0;
          p2_score_d = 3'd0;
          winner_d   = 2'b00;
          prio_d     = 1'b0;
        end
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (pattern_ack) begin
          trace_d = (pattern_in == 16'h0000) ? DEFAULT_PATTERN : pattern_in;
          timer_d = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (hit1 || hit2) begin
          state_d        = S_RESULT;
          timer_d        = '0;
          result_valid_d = 1'b1;
          if (p1_takes) begin
            winner_d   = 2'b01;
            p1_score_d = p1_inc;
          end else begin
            winner_d   = 2'b10;
            p2_score_d = p2_inc;
          end
          if (hit1 && hit2) prio_d = ~prio_q;
        end else if (timer_q == PLAY_LAST) begin
          state_d        = S_RESULT;
          timer_d        = '0;
          result_valid_d = 1'b1;
          winner_d       = 2'b00;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESULT: begin
        if (timer_q == RESULT_LAST) begin
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 3'd1;
            state_d = S_FETCH;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d        = S_IDLE;
      round_d        = 3'd0;
      p1_score_d     = 3'd0;
      p2_score_d     = 3'd0;
      winner_d       = 2'b00;
      result_valid_d = 1'b0;
      prio_d         = 1'b0;
      timer_d        = '0;
    end
  end

  // State and datapath registers with asynchronous reset to the power-up values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      round_q        <= 3'd0;
      p1_score_q     <= 3'd0;
      p2_score_q     <= 3'd0;
      winner_q       <= 2'b00;
      result_valid_q <= 1'b0;
      trace_q        <= DEFAULT_PATTERN;
      prio_q         <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      winner_q       <= winner_d;
      result_valid_q <= result_valid_d;
      trace_q        <= trace_d;
      prio_q         <= prio_d;
      timer_q        <= timer_d;
    end
  end

  assign pattern_req      = (state_q == S_FETCH);
  assign trace_screen_on  = (state_q == S_PLAY);
  assign game_over        = (state_q == S_DONE);
  assign trace_to_display = trace_q;
  assign round            = round_q;
  assign p1_score         = p1_score_q;
  assign p2_score         = p2_score_q;
  assign round_winner     = winner_q;
  assign result_valid     = result_valid_q;

endmodule

// File: tb/tb_trace_round_sequencer.sv
// Directed testbench for trace_round_sequencer with short timeouts
// (ROUND_TIMEOUT=20, RESULT_CYCLES=4, NUM_ROUNDS=3).
module tb_trace_round_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        two_player_mode = 1'b0;
  logic [15:0] p1_traced = 16'h0;
  logic        p1_valid = 1'b0;
  logic [15:0] p2_traced = 16'h0;
  logic        p2_valid = 1'b0;
  logic        pattern_req;
  logic        pattern_ack = 1'b0;
  logic [15:0] pattern_in = 16'h0;
  logic [15:0] trace_to_display;
  logic        trace_screen_on;
  logic [2:0]  round;
  logic [2:0]  p1_score;
  logic [2:0]  p2_score;
  logic [1:0]  round_winner;
  logic        result_valid;
  logic        game_over;

  int n_cmp = 0;
  int n_err = 0;

  trace_round_sequencer #(
    .NUM_ROUNDS(3), .ROUND_TIMEOUT(20), .RESULT_CYCLES(4), .TMR_W(28)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .two_player_mode(two_player_mode),
    .p1_traced(p1_traced), .p1_valid(p1_valid),
    .p2_traced(p2_traced), .p2_valid(p2_valid),
    .pattern_req(pattern_req), .pattern_ack(pattern_ack), .pattern_in(pattern_in),
    .trace_to_display(trace_to_display), .trace_screen_on(trace_screen_on),
    .round(round), .p1_score(p1_score), .p2_score(p2_score),
    .round_winner(round_winner), .result_valid(result_valid), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a pattern request, then acknowledge with the given pattern.
  task automatic do_fetch(input logic [15:0] pat);
    int k = 0;
    while (!pattern_req && k < 10) begin
      tick();
      k++;
    end
    n_cmp++;
    if (pattern_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL fetch_wait: pattern_req got %b want 1", pattern_req);
    end
    pattern_in  = pat;
    pattern_ack = 1'b1;
    tick();
    pattern_ack = 1'b0;
    pattern_in  = 16'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (trace_to_display !== 16'h0231) begin n_err++; $display("[TB] FAIL rst_trace: got %h want 0231", trace_to_display); end
    n_cmp++; if (pattern_req !== 1'b0) begin n_err++; $display("[TB] FAIL rst_req: got %b want 0", pattern_req); end
    n_cmp++; if (trace_screen_on !== 1'b0) begin n_err++; $display("[TB] FAIL rst_screen: got %b want 0", trace_screen_on); end
    n_cmp++; if ({round, p1_score, p2_score} !== 9'd0) begin n_err++; $display("[TB] FAIL rst_counts: got %h/%h/%h want 0/0/0", round, p1_score, p2_score); end
    n_cmp++; if ({round_winner, result_valid, game_over} !== 4'd0) begin n_err++; $display("[TB] FAIL rst_flags: got %b want 0000", {round_winner, result_valid, game_over}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_p1_win();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (pattern_req !== 1'b1) begin n_err++; $display("[TB] FAIL p1_req: got %b want 1", pattern_req); end
    do_fetch(16'h00F0);
    n_cmp++; if (pattern_req !== 1'b0) begin n_err++; $display("[TB] FAIL p1_req_drop: got %b want 0", pattern_req); end
    n_cmp++; if (trace_screen_on !== 1'b1) begin n_err++; $display("[TB] FAIL p1_screen: got %b want 1", trace_screen_on); end
    n_cmp++; if (trace_to_display !== 16'h00F0) begin n_err++; $display("[TB] FAIL p1_trace: got %h want 00f0", trace_to_display); end
    p1_traced = 16'h01F0;
    p1_valid  = 1'b1;
    tick();
    n_cmp++; if (round_winner !== 2'b01) begin n_err++; $display("[TB] FAIL p1_winner: got %b want 01", round_winner); end
    n_cmp++; if (p1_score !== 3'd1) begin n_err++; $display("[TB] FAIL p1_score: got %0d want 1", p1_score); end
    n_cmp++; if (result_valid !== 1'b1) begin n_err++; $display("[TB] FAIL p1_rv_on: got %b want 1", result_valid); end
    tick();
    p1_valid = 1'b0;
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("[TB] FAIL p1_rv_off: got %b want 0", result_valid); end
    n_cmp++; if (p1_score !== 3'd1) begin n_err++; $display("[TB] FAIL p1_result_strobe: score got %0d want 1", p1_score); end
    tick();
    tick();
    n_cmp++; if (pattern_req !== 1'b0) begin n_err++; $display("[TB] FAIL p1_result_hold: req got %b want 0", pattern_req); end
    tick();
    n_cmp++; if (pattern_req !== 1'b1) begin n_err++; $display("[TB] FAIL p1_next_fetch: req got %b want 1", pattern_req); end
    n_cmp++; if (round !== 3'd1) begin n_err++; $display("[TB] FAIL p1_round: got %0d want 1", round); end
  endtask

  task automatic test_back_to_back_tie();
    two_player_mode = 1'b1;
    do_fetch(16'h0F00);
    p1_traced = 16'h0F00; p1_valid = 1'b1;
    p2_traced = 16'h0FF0; p2_valid = 1'b1;
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    n_cmp++; if (round_winner !== 2'b01) begin n_err++; $display("[TB] FAIL tie1_winner: got %b want 01", round_winner); end
    n_cmp++; if ({p1_score, p2_score} !== {3'd2, 3'd0}) begin n_err++; $display("[TB] FAIL tie1_scores: got %0d/%0d want 2/0", p1_score, p2_score); end
    repeat (4) tick();
    do_fetch(16'h1111);
    p1_traced = 16'h1111; p1_valid = 1'b1;
    p2_traced = 16'h1111; p2_valid = 1'b1;
    tick();
    p1_valid = 1'b0; p2_valid = 1'b0;
    n_cmp++; if (round_winner !== 2'b10) begin n_err++; $display("[TB] FAIL tie2_winner: got %b want 10", round_winner); end
    n_cmp++; if ({p1_score, p2_score} !== {3'd2, 3'd1}) begin n_err++; $display("[TB] FAIL tie2_scores: got %0d/%0d want 2/1", p1_score, p2_score); end
    repeat (4) tick();
    n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("[TB] FAIL done_flag: got %b want 1", game_over); end
    n_cmp++; if (round !== 3'd2) begin n_err++; $display("[TB] FAIL done_round: got %0d want 2", round); end
    n_cmp++; if (pattern_req !== 1'b0) begin n_err++; $display("[TB] FAIL done_req: got %b want 0", pattern_req); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (pattern_req !== 1'b1) begin n_err++; $display("[TB] FAIL restart_req: got %b want 1", pattern_req); end
    n_cmp++; if ({round, p1_score, p2_score, game_over} !== 10'd0) begin n_err++; $display("[TB] FAIL restart_clear: got %0d/%0d/%0d/%b want 0/0/0/0", round, p1_score, p2_score, game_over); end
  endtask

  task automatic test_timeout_single();
    two_player_mode = 1'b0;
    do_fetch(16'h0003);
    p2_traced = 16'hFFFF; p2_valid = 1'b1;
    tick();
    p2_valid = 1'b0;
    n_cmp++; if ({trace_screen_on, result_valid, p2_score} !== {1'b1, 1'b0, 3'd0}) begin n_err++; $display("[TB] FAIL p2_ignored: got %b/%b/%0d want 1/0/0", trace_screen_on, result_valid, p2_score); end
    repeat (18) tick();
    n_cmp++; if (trace_screen_on !== 1'b1) begin n_err++; $display("[TB] FAIL to_last_cycle: screen got %b want 1", trace_screen_on); end
    tick();
    n_cmp++; if ({result_valid, trace_screen_on} !== 2'b10) begin n_err++; $display("[TB] FAIL to_result: got %b want 10", {result_valid, trace_screen_on}); end
    n_cmp++; if ({round_winner, p1_score, p2_score} !== 8'd0) begin n_err++; $display("[TB] FAIL to_winner: got %b/%0d/%0d want 00/0/0", round_winner, p1_score, p2_score); end
    repeat (4) tick();
  endtask

  task automatic test_zero_pattern();
    do_fetch(16'h0000);
    n_cmp++; if (trace_to_display !== 16'h0231) begin n_err++; $display("[TB] FAIL zero_pat: got %h want 0231", trace_to_display); end
    p1_traced = 16'h0230; p1_valid = 1'b1;
    tick();
    n_cmp++; if ({trace_screen_on, result_valid} !== 2'b10) begin n_err++; $display("[TB] FAIL near_miss: got %b want 10", {trace_screen_on, result_valid}); end
    p1_traced = 16'h0231;
    tick();
    p1_valid = 1'b0;
    n_cmp++; if ({round_winner, p1_score} !== {2'b01, 3'd1}) begin n_err++; $display("[TB] FAIL zero_hit: got %b/%0d want 01/1", round_winner, p1_score); end
    repeat (4) tick();
  endtask

  task automatic test_abort_reset();
    n_cmp++; if ({pattern_req, round} !== {1'b1, 3'd2}) begin n_err++; $display("[TB] FAIL pre_abort: got %b/%0d want 1/2", pattern_req, round); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if ({pattern_req, round, p1_score} !== 7'd0) begin n_err++; $display("[TB] FAIL abort_clear: got %b/%0d/%0d want 0/0/0", pattern_req, round, p1_score); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (pattern_req !== 1'b1) begin n_err++; $display("[TB] FAIL abort_restart: got %b want 1", pattern_req); end
    do_fetch(16'h00F0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (trace_screen_on !== 1'b1) begin n_err++; $display("[TB] FAIL start_in_play: screen got %b want 1", trace_screen_on); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({trace_screen_on, pattern_req, game_over} !== 3'b000) begin n_err++; $display("[TB] FAIL midreset_flags: got %b want 000", {trace_screen_on, pattern_req, game_over}); end
    n_cmp++; if (trace_to_display !== 16'h0231) begin n_err++; $display("[TB] FAIL midreset_trace: got %h want 0231", trace_to_display); end
    #2;
    reset = 1'b0;
    tick();
    n_cmp++; if ({pattern_req, trace_screen_on, round} !== 5'd0) begin n_err++; $display("[TB] FAIL post_reset_idle: got %b/%b/%0d want 0/0/0", pattern_req, trace_screen_on, round); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] trace_round_sequencer directed test start");
    test_reset();
    test_p1_win();
    test_back_to_back_tie();
    test_timeout_single();
    test_zero_pattern();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
